cc_bus_arbiter: RTL

//  Shares the CPU data bus mux between NUM_REQ requesters using round-robin arbitration.

---
 rtl/cc_bus_arbiter_pkg.sv | 16 +
 rtl/cc_bus_arbiter_picker.sv | 39 +++
 rtl/cc_bus_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cc_bus_arbiter_pkg.sv
// Shared encodings for the CPU data bus arbiter: FSM states, source types
// and default code widths.
package cc_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    localparam logic SRC_REGISTER = 1'b1;
    localparam logic SRC_CONTROL  = 1'b0;

    localparam int REG_CODE_W = 5;
    localparam int CTL_CODE_W = 6;

endpackage

// File: rtl/cc_bus_arbiter_picker.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping past the top index.
module cc_rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic               any
);

    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, pointer} + (PTR_W+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cc_bus_arbiter.sv
// Round-robin owner of the CPU data bus mux with a per-grant hold watchdog.
// All outputs are registered; mux inputs keep their value between grants.
//
//  state   | meaning
//  IDLE    | sample requests, pick winner from rr pointer
//  SETUP   | grant up, mux inputs settling, valid low
//  HOLD    | valid high, hold counter running
//  RECOVER | bus turnaround, advance pointer past last owner
module cc_bus_arbiter
    import cc_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ                         = 4,
    parameter int DATAWIDTH_MUX_SELECTION_REG     = REG_CODE_W,
    parameter int DATAWIDTH_MUX_SELECTION_CONTROL = CTL_CODE_W,
    parameter int MAX_HOLD                        = 8
) (
    input  logic                                               CC_BUSARB_CLOCK_50,
    input  logic                                               CC_BUSARB_RESET_InLow,
    input  logic [NUM_REQ-1:0]                                 CC_BUSARB_request_InBUS,
    input  logic [NUM_REQ-1:0]                                 CC_BUSARB_srcType_InBUS,
    input  logic [NUM_REQ*DATAWIDTH_MUX_SELECTION_CONTROL-1:0] CC_BUSARB_code_InBUS,
    output logic [NUM_REQ-1:0]                                 CC_BUSARB_grant_OutBUS,
    output logic                                               CC_BUSARB_valid_Out,
    output logic                                               CC_BUSARB_selector_Out,
    output logic [DATAWIDTH_MUX_SELECTION_REG-1:0]             CC_BUSARB_registro_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION_CONTROL-1:0]         CC_BUSARB_control_OutBUS,
    output logic                                               CC_BUSARB_timeout_Out
);

    localparam int RW    = DATAWIDTH_MUX_SELECTION_REG;
    localparam int CW    = DATAWIDTH_MUX_SELECTION_CONTROL;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);

    logic [1:0]         state;
    logic [1:0]         stateNext;
    logic [PTR_W-1:0]   pointer;
    logic [PTR_W-1:0]   ownerIdx;
    logic [PTR_W-1:0]   winIdx;
    logic [NUM_REQ-1:0] winner;
    logic               reqAny;
    logic [CNT_W-1:0]   holdCnt;
    logic               ownerReq;
    logic               holdExpired;
    logic               latchWinner;
    logic               srcSel;
    logic [CW-1:0]      codeSel;

    cc_rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) uPicker (
        .req     (CC_BUSARB_request_InBUS),
        .pointer (pointer),
        .winner  (winner),
        .any     (reqAny)
    );

    always_comb begin
        winIdx  = '0;
        srcSel  = SRC_CONTROL;
        codeSel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                winIdx  = PTR_W'(i);
                srcSel  = CC_BUSARB_srcType_InBUS[i];
                codeSel = CC_BUSARB_code_InBUS[i*CW +: CW];
            end
        end
    end

    assign ownerReq    = CC_BUSARB_request_InBUS[ownerIdx];
    assign holdExpired = (holdCnt == HOLD_LIMIT);
    assign latchWinner = (state == ST_IDLE) && reqAny;

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (reqAny) begin
                    stateNext = ST_SETUP;
                end
            end
            ST_SETUP: begin
                stateNext = ownerReq ? ST_HOLD : ST_RECOVER;
            end
            ST_HOLD: begin
                if (!ownerReq || holdExpired) begin
                    stateNext = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CC_BUSARB_CLOCK_50 or negedge CC_BUSARB_RESET_InLow) begin
        if (!CC_BUSARB_RESET_InLow) begin
            state    <= ST_IDLE;
            pointer  <= '0;
            ownerIdx <= '0;
            holdCnt  <= '0;
        end else begin
            state <= stateNext;
            if (latchWinner) begin
                ownerIdx <= winIdx;
            end
            if (state == ST_IDLE) begin
                holdCnt <= '0;
            end else if (stateNext == ST_HOLD) begin
                holdCnt <= holdCnt + 1'b1;
            end
            if (state == ST_RECOVER) begin
                pointer <= (ownerIdx == LAST_IDX) ? '0 : ownerIdx + 1'b1;
            end
        end
    end

    // Watchdog release is distinguished from a normal drop only by the timeout pulse.
    always_ff @(posedge CC_BUSARB_CLOCK_50 or negedge CC_BUSARB_RESET_InLow) begin
        if (!CC_BUSARB_RESET_InLow) begin
            CC_BUSARB_grant_OutBUS <= '0;
            CC_BUSARB_valid_Out    <= 1'b0;
            CC_BUSARB_timeout_Out  <= 1'b0;
        end else begin
            CC_BUSARB_valid_Out   <= (stateNext == ST_HOLD);
            CC_BUSARB_timeout_Out <= (state == ST_HOLD) && ownerReq && holdExpired;
            if (latchWinner) begin
                CC_BUSARB_grant_OutBUS <= winner;
            end else if (stateNext == ST_RECOVER) begin
                CC_BUSARB_grant_OutBUS <= '0;
            end
        end
    end

    // Mux inputs only move on a new grant so the bus sees no glitch between owners.
    always_ff @(posedge CC_BUSARB_CLOCK_50 or negedge CC_BUSARB_RESET_InLow) begin
        if (!CC_BUSARB_RESET_InLow) begin
            CC_BUSARB_selector_Out    <= 1'b0;
            CC_BUSARB_registro_OutBUS <= '0;
            CC_BUSARB_control_OutBUS  <= '0;
        end else if (latchWinner) begin
            if (srcSel == SRC_REGISTER) begin
                CC_BUSARB_selector_Out    <= 1'b1;
                CC_BUSARB_registro_OutBUS <= codeSel[RW-1:0];
                CC_BUSARB_control_OutBUS  <= '0;
            end else begin
                CC_BUSARB_selector_Out    <= 1'b0;
                CC_BUSARB_registro_OutBUS <= '0;
                CC_BUSARB_control_OutBUS  <= codeSel;
            end
        end
    end

endmodule
